// File: rtl/power_burst_seq.sv
// power_burst_seq
// Burst activity sequencer for an IO bank: runs BURST_LEN cycles of toggling
// activity, optionally separated by GAP_LEN idle cycles, REPEAT times
// (REPEAT=0 repeats until abort), then pulses done.
//
// Build option: define PWR_SEQ_LFSR_EN to drive act_data from a maximal-length
// Fibonacci LFSR (seed 1) instead of the default binary up-counter.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-high reset
//   cfg_we     : config write strobe (honoured only while idle)
//   cfg_addr   : 0=BURST_LEN, 1=GAP_LEN, 2=REPEAT, 3=reserved
//   cfg_data   : config write data
//   start      : begin a sequence (level, ignored while busy)
//   abort      : return to IDLE next cycle from any state, no done pulse
//   act_en     : high during RUN
//   act_data   : activity pattern, advances once per RUN cycle
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse on normal completion
//   burst_idx  : completed bursts in the current sequence
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for start; config writes accepted
// RUN   | burst active, act_en=1, act_data advancing
// GAP   | inter-burst pause, act_en=0
// DONE  | single cycle with done=1, then back to IDLE
module power_burst_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             start,
  input  logic             abort,
  output logic             act_en,
  output logic [CNT_W-1:0] act_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] burst_idx
);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           state;
  logic [CNT_W-1:0] burst_len;
  logic [CNT_W-1:0] gap_len;
  logic [CNT_W-1:0] repeat_cnt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] burst_load;
  logic [CNT_W-1:0] data_next;
  logic [CNT_W-1:0] data_seed;
  logic             last_burst;

  // A burst of length 0 is treated as length 1; the timer counts down to 0.
  assign burst_load = (burst_len == ZERO) ? ZERO : burst_len - ONE;
  assign last_burst = (repeat_cnt != ZERO) && ((burst_idx + ONE) == repeat_cnt);

`ifdef PWR_SEQ_LFSR_EN
  // Tap masks (bit n-1 set for tap n) for common widths; 8-bit uses x^8+x^6+x^5+x^4+1.
  localparam logic [31:0] TAPS32 =
    (CNT_W == 4)  ? 32'h0000_000C :
    (CNT_W == 5)  ? 32'h0000_0014 :
    (CNT_W == 6)  ? 32'h0000_0030 :
    (CNT_W == 7)  ? 32'h0000_0060 :
    (CNT_W == 16) ? 32'h0000_D008 :
                    32'h0000_00B8;
  localparam logic [CNT_W-1:0] TAPS = TAPS32[CNT_W-1:0];

  assign data_seed = ONE;
  assign data_next = {act_data[CNT_W-2:0], ^(act_data & TAPS)};
`else
  assign data_seed = ZERO;
  assign data_next = act_data + ONE;
`endif

  // Configuration registers; writes land only while the sequencer is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_len  <= ONE;
      gap_len    <= ZERO;
      repeat_cnt <= ONE;
    end else if (cfg_we && (state == IDLE)) begin
      case (cfg_addr)
        2'd0:    burst_len  <= cfg_data;
        2'd1:    gap_len    <= cfg_data;
        2'd2:    repeat_cnt <= cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= ZERO;
      burst_idx <= ZERO;
      act_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      act_data  <= data_seed;
    end else begin
      done <= 1'b0;
      if (state == RUN) act_data <= data_next;

      if (abort) begin
        state     <= IDLE;
        act_en    <= 1'b0;
        busy      <= 1'b0;
        burst_idx <= ZERO;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= RUN;
              timer     <= burst_load;
              burst_idx <= ZERO;
              act_en    <= 1'b1;
              busy      <= 1'b1;
            end
          end
          RUN: begin
            if (timer == ZERO) begin
              burst_idx <= burst_idx + ONE;
              if (last_burst) begin
                state  <= DONE;
                act_en <= 1'b0;
                done   <= 1'b1;
              end else if (gap_len != ZERO) begin
                state  <= GAP;
                timer  <= gap_len - ONE;
                act_en <= 1'b0;
              end else begin
                // Back-to-back bursts: stay in RUN and reload.
                timer <= burst_load;
              end
            end else begin
              timer <= timer - ONE;
            end
          end
          GAP: begin
            if (timer == ZERO) begin
              state  <= RUN;
              timer  <= burst_load;
              act_en <= 1'b1;
            end else begin
              timer <= timer - ONE;
            end
          end
          DONE: begin
            state     <= IDLE;
            busy      <= 1'b0;
            burst_idx <= ZERO;
          end
          default: begin
            state  <= IDLE;
            act_en <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_power_burst_seq.sv
// Testbench for power_burst_seq (CNT_W=8). The expected per-cycle behaviour of
// a whole sequence is built as a list from the configured lengths, then the
// DUT outputs are compared against it one cycle at a time.
module tb_power_burst_seq;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_data;
  logic             start;
  logic             abort;
  logic             act_en;
  logic [CNT_W-1:0] act_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] burst_idx;

  power_burst_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .abort     (abort),
    .act_en    (act_en),
    .act_data  (act_data),
    .busy      (busy),
    .done      (done),
    .burst_idx (burst_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit bsy;
    bit dn;
    int idx;
  } exp_t;

  int   n_asserts = 0;
  int   n_fail    = 0;
  int   m_len, m_gap, m_rep;      // model of the config registers
  logic [7:0] m_data;             // model of act_data
  exp_t q[$];

`ifdef PWR_SEQ_LFSR_EN
  localparam logic [7:0] SEED = 8'd1;
  function automatic logic [7:0] model_next(input logic [7:0] d);
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
  endfunction
`else
  localparam logic [7:0] SEED = 8'd0;
  function automatic logic [7:0] model_next(input logic [7:0] d);
    return 8'((int'(d) + 1) % 256);
  endfunction
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input exp_t e);
    chk({tag, ".act_en"},    int'(act_en),    int'(e.en));
    chk({tag, ".busy"},      int'(busy),      int'(e.bsy));
    chk({tag, ".done"},      int'(done),      int'(e.dn));
    chk({tag, ".burst_idx"}, int'(burst_idx), e.idx);
    chk({tag, ".act_data"},  int'(act_data),  int'(m_data));
  endtask

  task automatic reset_model();
    m_len  = 1;
    m_gap  = 0;
    m_rep  = 1;
    m_data = SEED;
  endtask

  // Called at a negedge; leaves the bench at a later negedge.
  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = 2'(addr);
    cfg_data = 8'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    case (addr)
      0: m_len = data;
      1: m_gap = data;
      2: m_rep = data;
      default: ;
    endcase
  endtask

  // Expected cycle list of one sequence, starting with the first RUN cycle.
  task automatic build_expect();
    int b;
    int len;
    q.delete();
    b   = 0;
    len = (m_len == 0) ? 1 : m_len;
    while (q.size() < 700) begin
      repeat (len) q.push_back('{1'b1, 1'b1, 1'b0, b % 256});
      b++;
      if (m_rep != 0 && b == m_rep) begin
        q.push_back('{1'b0, 1'b1, 1'b1, m_rep});
        q.push_back('{1'b0, 1'b0, 1'b0, 0});
        break;
      end
      repeat (m_gap) q.push_back('{1'b0, 1'b1, 1'b0, b % 256});
    end
  endtask

  // abort_at / wr_at / st_at: cycle index (into the expected list) at which to
  // raise abort, attempt a BURST_LEN=9 write, or re-pulse start; -1 = never.
  task automatic run_seq(input string tag, input int abort_at, input int wr_at, input int st_at);
    build_expect();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      chk_cycle($sformatf("%s[%0d]", tag, i), q[i]);
      if (q[i].en) m_data = model_next(m_data);
      start    = (i == st_at);
      cfg_we   = (i == wr_at);
      cfg_addr = 2'd0;
      cfg_data = 8'd9;
      abort    = (i == abort_at);
      @(negedge clk);
      start  = 1'b0;
      cfg_we = 1'b0;
      if (i == abort_at) begin
        abort = 1'b0;
        chk_cycle({tag, ".after_abort"}, '{1'b0, 1'b0, 1'b0, 0});
        break;
      end
    end
  endtask

  initial begin
    int ab;
    rst      = 1'b1;
    cfg_we   = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = '0;
    start    = 1'b0;
    abort    = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    chk_cycle("reset", '{1'b0, 1'b0, 1'b0, 0});
    rst = 1'b0;
    @(negedge clk);
    chk_cycle("idle_after_reset", '{1'b0, 1'b0, 1'b0, 0});

    // Default config: one 1-cycle burst then done.
    run_seq("default", -1, -1, -1);

    // 4-cycle bursts, 2-cycle gaps, 3 repeats.
    cfg_write(0, 4);
    cfg_write(1, 2);
    cfg_write(2, 3);
    run_seq("b4g2r3", -1, -1, -1);

    // Config write and restart while busy are ignored.
    cfg_write(1, 0);
    cfg_write(2, 1);
    run_seq("busy_write", -1, 1, 2);
    cfg_write(0, 9);
    run_seq("idle_write", -1, -1, -1);

    // Reserved address does not disturb the real registers.
    cfg_write(3, 0);
    run_seq("reserved", -1, -1, -1);

    // Infinite repeat, aborted at cycle 10.
    cfg_write(0, 3);
    cfg_write(1, 0);
    cfg_write(2, 0);
    run_seq("infinite_abort", 10, -1, -1);

    // start together with abort in IDLE stays idle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_cycle("start_abort", '{1'b0, 1'b0, 1'b0, 0});
    @(negedge clk);
    chk_cycle("start_abort2", '{1'b0, 1'b0, 1'b0, 0});

    // burst_idx wraps past 255 with single-cycle bursts.
    cfg_write(0, 1);
    run_seq("idx_wrap", 300, -1, -1);

    // Randomised configurations, with occasional aborts.
    for (int k = 0; k < 8; k++) begin
      cfg_write(0, $urandom_range(0, 5));
      cfg_write(1, $urandom_range(0, 3));
      cfg_write(2, $urandom_range(0, 4));
      if (m_rep == 0) ab = $urandom_range(0, 40);
      else if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 20);
      else ab = -1;
      run_seq($sformatf("rand%0d", k), ab, -1, -1);
    end

`ifdef PWR_SEQ_LFSR_EN
    // 255 RUN cycles give 255 distinct nonzero patterns.
    begin
      bit seen [256];
      int distinct;
      distinct = 0;
      for (int v = 0; v < 256; v++) seen[v] = 1'b0;
      cfg_write(0, 255);
      cfg_write(1, 0);
      cfg_write(2, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 255; i++) begin
        if (act_data != 8'd0 && !seen[act_data]) distinct++;
        seen[act_data] = 1'b1;
        m_data = model_next(m_data);
        @(negedge clk);
      end
      chk("lfsr_distinct", distinct, 255);
      chk("lfsr_done", int'(done), 1);
      @(negedge clk);
    end
`endif

    // Reset in the middle of a burst.
    cfg_write(0, 6);
    cfg_write(1, 0);
    cfg_write(2, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset.act_en", int'(act_en), 1);
    rst = 1'b1;
    #1;
    reset_model();
    chk_cycle("mid_reset", '{1'b0, 1'b0, 1'b0, 0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cycle("post_reset_idle", '{1'b0, 1'b0, 1'b0, 0});
    run_seq("default_after_reset", -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/power_burst_seq.md
POWER_BURST_SEQ -- requirements
Module: power_burst_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of act_data and all length registers.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port cfg_we, input, 1: config write strobe, sampled on clk.
REQ-005 SHALL have port cfg_addr, input, 2: register select; 0=BURST_LEN, 1=GAP_LEN, 2=REPEAT, 3=reserved (writes ignored).
REQ-006 SHALL have port cfg_data, input, CNT_W: config write data.
REQ-007 SHALL have port start, input, 1: begin a sequence; level-sampled.
REQ-008 SHALL have port abort, input, 1: terminate the sequence immediately.
REQ-009 SHALL have port act_en, output, 1: high while the toggle datapath is active (RUN).
REQ-010 SHALL have port act_data, output, CNT_W: activity pattern driven to the IO bank.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-013 SHALL have port burst_idx, output, CNT_W: count of completed bursts in the current sequence.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, GAP and DONE.
REQ-015 SHALL leave IDLE for RUN when start=1 and abort=0; act_en SHALL be high from the next cycle.
REQ-016 SHALL hold RUN for max(BURST_LEN,1) cycles; act_data SHALL update every RUN cycle and hold its value outside RUN.
REQ-017 SHALL, at the end of a burst, increment burst_idx; the next state SHALL be DONE if burst_idx+1==REPEAT and REPEAT!=0, GAP if GAP_LEN!=0, and RUN otherwise.
REQ-018 SHALL hold GAP for GAP_LEN cycles with act_en=0, then return to RUN.
REQ-019 SHALL treat REPEAT=0 as infinite: bursts repeat until abort.
REQ-020 SHALL hold DONE for exactly 1 cycle with done=1, then go to IDLE.
REQ-021 SHALL give abort priority over start and over every transition: any state goes to IDLE next cycle, act_en=0, and done is not asserted.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL ignore cfg_we while busy=1, and SHALL apply an IDLE-state write on the next cycle.
REQ-024 SHALL let burst_idx wrap modulo 2^CNT_W when REPEAT=0.
REQ-025 SHALL clear burst_idx on the IDLE->RUN transition.
REQ-026 SHALL keep act_data unchanged on the IDLE->RUN transition; it advances only on RUN cycles.
REQ-027 SHALL clear burst_idx when the FSM passes through DONE or abort to IDLE, so that it reads 0 while idle.

Reset
REQ-028 SHALL, while rst=1, force the state to IDLE and act_en=0, busy=0, done=0, burst_idx=0.
REQ-029 SHALL, while rst=1, force act_data to 0 in counter mode or to 1 in LFSR mode.
REQ-030 SHALL, while rst=1, reset BURST_LEN=1, GAP_LEN=0 and REPEAT=1.
REQ-031 SHALL, when rst asserts mid-sequence, drop act_en asynchronously without any done pulse.

Configuration
REQ-032 SHALL use the macro PWR_SEQ_LFSR_EN; when it is defined, act_data SHALL advance as a maximal-length Fibonacci LFSR (CNT_W=8 taps 8,6,5,4; seed 1; never 0).
REQ-033 SHALL, without PWR_SEQ_LFSR_EN, advance act_data as a binary up-counter by +1 per RUN cycle, wrapping 2^CNT_W-1 to 0.

Verification
REQ-034 SHALL cover: default config, pulse start -> act_en high for 1 cycle, done pulses 1 cycle later, act_data=1 (counter mode).
REQ-035 SHALL cover: BURST_LEN=4, GAP_LEN=2, REPEAT=3, start -> act_en pattern 1111 00 1111 00 1111, then done, burst_idx sequence 1,2,3.
REQ-036 SHALL cover: REPEAT=0, BURST_LEN=3, GAP_LEN=0, abort at cycle 10 -> act_en continuous, then 0 next cycle, no done, busy=0.
REQ-037 SHALL cover: cfg write BURST_LEN=9 while busy -> ignored, burst still 4 cycles; the same write in IDLE takes effect on the next start.
REQ-038 SHALL cover: start and abort asserted together in IDLE -> the FSM stays in IDLE with busy=0.
REQ-039 SHALL cover: rst asserted mid-RUN -> all outputs at reset values immediately; with PWR_SEQ_LFSR_EN defined, 255 RUN cycles produce 255 distinct nonzero act_data values.
